seq_control_unit: RTL and testbench

Parametrised multi-cycle controller for the register-file/ALU datapath: NREGS general registers, DATA_W-bit instructions and data. It fetches one instruction into an internal instruction register and sequences the source select, S-register load, ALU/C-register load and write-back. Variable-length execution: ALU ops take 4 cycles, moves take 3. Sits between the instruction source (d_in) and the datapath mux/ALU/register enables; adds an error flag and a retired-instruction counter.

---
 rtl/seq_cu_pkg.sv | 27 ++
 rtl/seq_cu_decode.sv | 34 +++
 rtl/seq_control_unit.sv | 105 ++++++++++
 tb/tb_seq_control_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_cu_pkg.sv
// Shared types and constants for the sequenced register-file/ALU controller.
package seq_cu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        LOAD_S = 2'd1,
        EXEC   = 2'd2,
        WRITE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_RR  = 2'b00;
    localparam logic [1:0] MODE_RI  = 2'b01;
    localparam logic [1:0] MODE_MV  = 2'b10;
    localparam logic [1:0] MODE_MVI = 2'b11;

    // ALU operation that forwards operand B unchanged (used by moves).
    localparam logic [2:0] ALU_PASSB = 3'd7;

    function automatic logic mode_is_alu(input logic [1:0] mode);
        return (mode == MODE_RR) || (mode == MODE_RI);
    endfunction

    function automatic logic mode_uses_imm(input logic [1:0] mode);
        return (mode == MODE_RI) || (mode == MODE_MVI);
    endfunction

endpackage

// File: rtl/seq_cu_decode.sv
// Instruction field extraction, immediate zero-extension and write-back enable decode.
module seq_cu_decode
    import seq_cu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    localparam int unsigned RW    = $clog2(NREGS)
) (
    input  logic [DATA_W-1:0] ir,
    output logic [RW-1:0]     rx,
    output logic [RW-1:0]     ry,
    output logic [2:0]        op,
    output logic [1:0]        mode,
    output logic [DATA_W-1:0] i_out,
    output logic [NREGS-1:0]  wb_en_r,
    output logic              wb_err
);

    assign rx    = ir[DATA_W-1 -: RW];
    assign ry    = ir[DATA_W-1-RW -: RW];
    assign op    = ir[4:2];
    assign mode  = ir[1:0];
    assign i_out = DATA_W'(ir[DATA_W-1-2*RW : 5]);

    // rx can encode more registers than exist when NREGS is not a power of two.
    always_comb begin
        wb_en_r = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            wb_en_r[i] = (32'(rx) == i);
        end
        wb_err = (32'(rx) >= NREGS);
    end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle controller: fetches an instruction and sequences S/C/register loads.
module seq_control_unit
    import seq_cu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned RW    = $clog2(NREGS),
    localparam int unsigned MW    = $clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] d_in,
    output logic [2:0]        alu_sel,
    output logic [MW-1:0]     mux_sel,
    output logic [DATA_W-1:0] i_out,
    output logic              en_i,
    output logic              en_s,
    output logic              en_c,
    output logic [NREGS-1:0]  en_r,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  instr_count
);

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   ir_q;
    logic [RW-1:0]       rx;
    logic [RW-1:0]       ry;
    logic [2:0]          op;
    logic [1:0]          mode;
    logic [NREGS-1:0]    wb_en_r;
    logic                wb_err;

    seq_cu_decode #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_decode (
        .ir      (ir_q),
        .rx      (rx),
        .ry      (ry),
        .op      (op),
        .mode    (mode),
        .i_out   (i_out),
        .wb_en_r (wb_en_r),
        .wb_err  (wb_err)
    );

    // Everything advances only on run=1 edges; outputs hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            ir_q        <= '0;
            instr_count <= '0;
        end else if (run) begin
            state_q <= state_d;
            if (state_q == FETCH) begin
                ir_q <= d_in;
            end
            if (state_q == WRITE) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = FETCH;
        alu_sel = '0;
        mux_sel = '0;
        en_i    = 1'b0;
        en_s    = 1'b0;
        en_c    = 1'b0;
        en_r    = '0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            FETCH: begin
                en_i    = 1'b1;
                // Path length is chosen from the word being fetched, not the old ir_q.
                state_d = mode_is_alu(d_in[1:0]) ? LOAD_S : EXEC;
            end
            LOAD_S: begin
                mux_sel = MW'(rx);
                en_s    = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                en_c    = 1'b1;
                mux_sel = mode_uses_imm(mode) ? MW'(NREGS) : MW'(ry);
                alu_sel = mode_is_alu(mode) ? op : ALU_PASSB;
                state_d = WRITE;
            end
            WRITE: begin
                done    = 1'b1;
                en_r    = wb_en_r;
                err     = wb_err;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench: default instance (8 regs) plus a 6-register, 2-bit-counter instance.
module tb_seq_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    int          total = 0;
    int          bad = 0;

    // Instance A: DATA_W=16, NREGS=8, CNT_W=16
    logic        run_a;
    logic [15:0] d_a;
    logic [2:0]  alu_a;
    logic [3:0]  mux_a;
    logic [15:0] iout_a;
    logic        eni_a, ens_a, enc_a, done_a, err_a;
    logic [7:0]  enr_a;
    logic [15:0] cnt_a;

    // Instance B: DATA_W=16, NREGS=6, CNT_W=2
    logic        run_b;
    logic [15:0] d_b;
    logic [2:0]  alu_b;
    logic [2:0]  mux_b;
    logic [15:0] iout_b;
    logic        eni_b, ens_b, enc_b, done_b, err_b;
    logic [5:0]  enr_b;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    seq_control_unit dut_a (
        .clk(clk), .reset(reset), .run(run_a), .d_in(d_a),
        .alu_sel(alu_a), .mux_sel(mux_a), .i_out(iout_a),
        .en_i(eni_a), .en_s(ens_a), .en_c(enc_a), .en_r(enr_a),
        .done(done_a), .err(err_a), .instr_count(cnt_a)
    );

    seq_control_unit #(.DATA_W(16), .NREGS(6), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .run(run_b), .d_in(d_b),
        .alu_sel(alu_b), .mux_sel(mux_b), .i_out(iout_b),
        .en_i(eni_b), .en_s(ens_b), .en_c(enc_b), .en_r(enr_b),
        .done(done_b), .err(err_b), .instr_count(cnt_b)
    );

    logic [19:0] obs_a;
    logic [16:0] obs_b;
    assign obs_a = {eni_a, ens_a, enc_a, done_a, err_a, alu_a, mux_a, enr_a};
    assign obs_b = {eni_b, ens_b, enc_b, done_b, err_b, alu_b, mux_b, enr_b};

    function automatic logic [19:0] ex_a(input logic i, s, c, d, e,
                                         input logic [2:0] alu, input logic [3:0] mux,
                                         input logic [7:0] r);
        return {i, s, c, d, e, alu, mux, r};
    endfunction

    function automatic logic [16:0] ex_b(input logic i, s, c, d, e,
                                         input logic [2:0] alu, input logic [2:0] mux,
                                         input logic [5:0] r);
        return {i, s, c, d, e, alu, mux, r};
    endfunction

    // {rx, ry, imm[4:0], op, mode} for 3-bit register fields
    function automatic logic [15:0] ins(input logic [2:0] rx, ry, input logic [4:0] imm,
                                        input logic [2:0] op, input logic [1:0] mode);
        return {rx, ry, imm, op, mode};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        run_a = 1'b0; run_b = 1'b0; d_a = '0; d_b = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #11;
        total++; if (obs_a !== ex_a(1,0,0,0,0,3'd0,4'd0,8'h00)) begin bad++; $display("FAIL reset_a_outs got=%h exp=%h", obs_a, ex_a(1,0,0,0,0,3'd0,4'd0,8'h00)); end
        total++; if (iout_a !== 16'h0000 || cnt_a !== 16'd0) begin bad++; $display("FAIL reset_a_regs got=%h/%h exp=0/0", iout_a, cnt_a); end
        total++; if (obs_b !== ex_b(1,0,0,0,0,3'd0,3'd0,6'h00) || cnt_b !== 2'd0) begin bad++; $display("FAIL reset_b got=%h/%h exp=%h/0", obs_b, cnt_b, ex_b(1,0,0,0,0,3'd0,3'd0,6'h00)); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_alu_rr();
        logic [19:0] e;
        d_a = 16'h2408; run_a = 1'b1;
        e = ex_a(1,0,0,0,0,3'd0,4'd0,8'h00);
        total++; if (obs_a !== e) begin bad++; $display("FAIL rr_fetch got=%h exp=%h", obs_a, e); end
        step();
        e = ex_a(0,1,0,0,0,3'd0,4'd1,8'h00);
        total++; if (obs_a !== e) begin bad++; $display("FAIL rr_loads got=%h exp=%h", obs_a, e); end
        step();
        e = ex_a(0,0,1,0,0,3'd2,4'd1,8'h00);
        total++; if (obs_a !== e) begin bad++; $display("FAIL rr_exec got=%h exp=%h", obs_a, e); end
        step();
        e = ex_a(0,0,0,1,0,3'd0,4'd0,8'h02);
        total++; if (obs_a !== e || cnt_a !== 16'd0) begin bad++; $display("FAIL rr_write got=%h/%0d exp=%h/0", obs_a, cnt_a, e); end
        step();
        total++; if (eni_a !== 1'b1 || cnt_a !== 16'd1) begin bad++; $display("FAIL rr_count got=%b/%0d exp=1/1", eni_a, cnt_a); end
    endtask

    task automatic test_alu_ri();
        logic [19:0] e;
        d_a = ins(3'd3, 3'd0, 5'h15, 3'd0, 2'b01);
        step();
        e = ex_a(0,1,0,0,0,3'd0,4'd3,8'h00);
        total++; if (obs_a !== e || iout_a !== 16'h0015) begin bad++; $display("FAIL ri_loads got=%h/%h exp=%h/0015", obs_a, iout_a, e); end
        step();
        e = ex_a(0,0,1,0,0,3'd0,4'd8,8'h00);
        total++; if (obs_a !== e) begin bad++; $display("FAIL ri_exec got=%h exp=%h", obs_a, e); end
        step();
        e = ex_a(0,0,0,1,0,3'd0,4'd0,8'h08);
        total++; if (obs_a !== e) begin bad++; $display("FAIL ri_write got=%h exp=%h", obs_a, e); end
        step();
        total++; if (eni_a !== 1'b1 || cnt_a !== 16'd2) begin bad++; $display("FAIL ri_count got=%b/%0d exp=1/2", eni_a, cnt_a); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] e;
        d_a = ins(3'd7, 3'd2, 5'h00, 3'd0, 2'b10);
        step();
        e = ex_a(0,0,1,0,0,3'd7,4'd2,8'h00);
        total++; if (obs_a !== e) begin bad++; $display("FAIL mv_exec got=%h exp=%h", obs_a, e); end
        d_a = 16'hFFFF;
        step();
        e = ex_a(0,0,0,1,0,3'd0,4'd0,8'h80);
        total++; if (obs_a !== e) begin bad++; $display("FAIL mv_write got=%h exp=%h", obs_a, e); end
        d_a = ins(3'd0, 3'd0, 5'h1C, 3'd0, 2'b11);
        step();
        total++; if (eni_a !== 1'b1 || cnt_a !== 16'd3) begin bad++; $display("FAIL mv_count got=%b/%0d exp=1/3", eni_a, cnt_a); end
        step();
        e = ex_a(0,0,1,0,0,3'd7,4'd8,8'h00);
        total++; if (obs_a !== e || iout_a !== 16'h001C) begin bad++; $display("FAIL mvi_exec got=%h/%h exp=%h/001c", obs_a, iout_a, e); end
        d_a = 16'hFFFF;
        step();
        e = ex_a(0,0,0,1,0,3'd0,4'd0,8'h01);
        total++; if (obs_a !== e) begin bad++; $display("FAIL mvi_write got=%h exp=%h", obs_a, e); end
        step();
        total++; if (eni_a !== 1'b1 || cnt_a !== 16'd4) begin bad++; $display("FAIL mvi_count got=%b/%0d exp=1/4", eni_a, cnt_a); end
    endtask

    task automatic test_stall();
        logic [19:0] e;
        d_a = ins(3'd5, 3'd4, 5'h00, 3'd3, 2'b00);
        step();
        step();
        run_a = 1'b0;
        e = ex_a(0,0,1,0,0,3'd3,4'd4,8'h00);
        for (int k = 0; k < 5; k++) begin
            step();
            total++; if (obs_a !== e) begin bad++; $display("FAIL stall_exec%0d got=%h exp=%h", k, obs_a, e); end
        end
        run_a = 1'b1;
        step();
        e = ex_a(0,0,0,1,0,3'd0,4'd0,8'h20);
        total++; if (obs_a !== e) begin bad++; $display("FAIL stall_resume got=%h exp=%h", obs_a, e); end
        step();
        total++; if (eni_a !== 1'b1 || cnt_a !== 16'd5) begin bad++; $display("FAIL stall_count got=%b/%0d exp=1/5", eni_a, cnt_a); end
        d_a = ins(3'd2, 3'd0, 5'h03, 3'd0, 2'b11);
        step();
        step();
        run_a = 1'b0;
        e = ex_a(0,0,0,1,0,3'd0,4'd0,8'h04);
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (obs_a !== e || cnt_a !== 16'd5) begin bad++; $display("FAIL stall_write%0d got=%h/%0d exp=%h/5", k, obs_a, cnt_a, e); end
        end
        run_a = 1'b1;
        step();
        total++; if (eni_a !== 1'b1 || cnt_a !== 16'd6) begin bad++; $display("FAIL stall_wb_count got=%b/%0d exp=1/6", eni_a, cnt_a); end
    endtask

    task automatic test_reset_mid();
        logic [19:0] e;
        d_a = ins(3'd6, 3'd1, 5'h00, 3'd4, 2'b00);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        e = ex_a(1,0,0,0,0,3'd0,4'd0,8'h00);
        total++; if (obs_a !== e || cnt_a !== 16'd0 || iout_a !== 16'h0000) begin bad++; $display("FAIL rstmid_abort got=%h/%0d/%h exp=%h/0/0", obs_a, cnt_a, iout_a, e); end
        @(posedge clk);
        #1 reset = 1'b0;
        total++; if (obs_a !== e) begin bad++; $display("FAIL rstmid_fetch got=%h exp=%h", obs_a, e); end
        step();
        e = ex_a(0,1,0,0,0,3'd0,4'd6,8'h00);
        total++; if (obs_a !== e) begin bad++; $display("FAIL rstmid_loads got=%h exp=%h", obs_a, e); end
        step();
        run_a = 1'b0;
        total++; if (done_a !== 1'b0 || enr_a !== 8'h00 || cnt_a !== 16'd0) begin bad++; $display("FAIL rstmid_quiet got=%b/%h/%0d exp=0/00/0", done_a, enr_a, cnt_a); end
    endtask

    task automatic test_err_wrap();
        logic [15:0] t_ins [4];
        logic [2:0]  t_mux [4];
        logic [5:0]  t_enr [4];
        logic        t_err [4];
        logic [1:0]  t_cnt [4];
        logic [16:0] e;
        t_ins[0] = ins(3'd7, 3'd0, 5'h01, 3'd0, 2'b11); t_mux[0] = 3'd6; t_enr[0] = 6'h00; t_err[0] = 1'b1; t_cnt[0] = 2'd1;
        t_ins[1] = ins(3'd5, 3'd3, 5'h00, 3'd0, 2'b10); t_mux[1] = 3'd3; t_enr[1] = 6'h20; t_err[1] = 1'b0; t_cnt[1] = 2'd2;
        t_ins[2] = ins(3'd6, 3'd0, 5'h02, 3'd0, 2'b11); t_mux[2] = 3'd6; t_enr[2] = 6'h00; t_err[2] = 1'b1; t_cnt[2] = 2'd3;
        t_ins[3] = ins(3'd0, 3'd1, 5'h00, 3'd0, 2'b10); t_mux[3] = 3'd1; t_enr[3] = 6'h01; t_err[3] = 1'b0; t_cnt[3] = 2'd0;
        run_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_b = t_ins[k];
            step();
            e = ex_b(0,0,1,0,0,3'd7,t_mux[k],6'h00);
            total++; if (obs_b !== e) begin bad++; $display("FAIL b_exec%0d got=%h exp=%h", k, obs_b, e); end
            step();
            e = ex_b(0,0,0,1,t_err[k],3'd0,3'd0,t_enr[k]);
            total++; if (obs_b !== e) begin bad++; $display("FAIL b_write%0d got=%h exp=%h", k, obs_b, e); end
            step();
            total++; if (eni_b !== 1'b1 || cnt_b !== t_cnt[k]) begin bad++; $display("FAIL b_count%0d got=%b/%0d exp=1/%0d", k, eni_b, cnt_b, t_cnt[k]); end
        end
        run_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_rr();
        test_alu_ri();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_err_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
